ro_mem_burst_responder: RTL and testbench
=========================================

# ro_mem_burst_responder

Responder end of the read-only burst memory interface that the instruction cache masters: `request`/`addr`/`rlen` in, `ack` and a stream of `rvalid`/`rdata` words out. It serves each line-fill request from a local synchronous RAM with fixed read latency, returning the aligned block word by word in ascending order. It sits where the L1 arbiter would otherwise be, for example in small single-master systems or as the bench model for cache line fills.

## Interface
- `RAM_ADDR_W`, 14: word-address width of the backing RAM. Upper request address bits are ignored.
- `READ_LATENCY`, 1: cycles from `ram_en` to valid `ram_rdata`. Legal range 1..4.
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `request`  in  1  initiator holds high until it samples `ack`
- `addr`  in  30  word address (byte address [31:2])
- `rlen`  in  5  burst length minus one
- `ack`  out  1  request accepted; single-cycle pulse
- `rvalid`  out  1  `rdata` carries the next burst word
- `rdata`  out  32  returned word
- `ram_en`  out  1  read strobe to backing RAM
- `ram_addr`  out  RAM_ADDR_W  RAM word address
- `ram_rdata`  in  32  RAM read data, valid READ_LATENCY cycles after `ram_en`
- `ram_ready`  in  1  RAM accepts a read this cycle; tie high for plain BRAM

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `ack = request` (combinational, only in IDLE).
  - On `ack`: latch `base = addr & ~zext(rlen)`, latch `len = rlen`, clear `offset`, and go to ISSUE.
- **ISSUE**
  - `ram_en = ram_ready`.
  - `ram_addr = base[RAM_ADDR_W-1:0] | zext(offset)`. This is a bitwise OR, so there is no carry out of the aligned block.
  - On `ram_en`, `offset` increments. If `offset == len`, go to DRAIN instead.
- **DRAIN**
  - Wait until the latency pipeline is empty, then go to IDLE.
- **Latency pipeline:** a READ_LATENCY-deep shift register of valid bits, fed by `ram_en`.
  - `rvalid` = last stage of the shift register.
  - `rdata = ram_rdata` (passthrough).
- **Ordering:** words are always returned as `base+0 .. base+len`, ascending and never reordered. Exactly `len+1` `rvalid` pulses are produced per `ack`.
- **Non-power-of-two `rlen`:** `base` still masks the bits that are set in `rlen`. Words are `base | k` for k = 0..len. This is deterministic, and the initiator is responsible for it.
- **Aliasing:** address bits above RAM_ADDR_W are dropped; no error is reported.
- **Request while busy:** not acked; stays pending and is acked on the first IDLE cycle.
- **Reset (also mid-burst):**
  - FSM returns to IDLE.
  - `offset`, `base`, `len` and the shift register are cleared.
  - In-flight RAM data is discarded and no further `rvalid` is produced.
- **Reset values:** `ack` 0, `rvalid` 0, `ram_en` 0, `ram_addr` 0. `rdata` follows `ram_rdata` and is meaningful only with `rvalid`.

## Timing
- `request` high in IDLE at cycle 0: `ack` at cycle 0.
- First `ram_en` at cycle 1; first `rvalid` at cycle 1+READ_LATENCY.
- With `ram_ready` held high, an N-word burst has:
  - `rvalid` on cycles 1+L .. N+L, contiguous (L = READ_LATENCY);
  - IDLE at cycle N+L+1.
- The earliest next `ack` is one cycle after the last `rvalid`. `rvalid` never appears in the `ack` cycle.
- A low `ram_ready` inserts bubbles one-for-one into the `rvalid` stream.
- Throughput: one word per cycle. Per-request overhead: L+1 cycles.

## Test plan
- **Aligned line fill.** Setup: L=1; RAM[i] = 0x1000+i; `request` with `addr`=0x13, `rlen`=7. Required: `ack` at cycle 0; `ram_addr` 0x10..0x17 on cycles 1..8; `rvalid` on cycles 2..9 with `rdata` 0x1010..0x1017; back in IDLE at cycle 10.
- **Single word.** `rlen`=0, `addr`=0x25. Required: exactly one `rvalid` with `rdata`=0x1025, at cycle 1+L, for L=1 and for L=3.
- **Backpressure.** `rlen`=3; `ram_ready` pattern 1,0,0,1,1,0,1. Required: 4 `rvalid` pulses, in order 0x1000..0x1003, each L cycles after its `ram_en`; no duplicates or gaps in data.
- **Held second request.** `request` stays high after the first `ack` with a new `addr`=0x40, `rlen`=3. Required: second `ack` exactly one cycle after the last `rvalid` of the first burst; returns 0x1040..0x1043.
- **Reset mid-burst.** `rlen`=7; `rst` one cycle after the third `rvalid`. Required: no further `rvalid`, and `ack`/`ram_en` stay low during reset. A following `rlen`=1, `addr`=0x8 request returns exactly 0x1008 and 0x1009.
- **Aliasing.** RAM_ADDR_W=4; `addr`=0x3F8, `rlen`=7. Required: `ram_addr` 0x8..0xF, and `rdata` is RAM[8..15].

Source files
------------

// File: rtl/ro_mem_burst_responder.sv
// Read-only burst responder: accepts a line-fill request, walks the aligned block word by word
// against a fixed-latency synchronous RAM, and returns words base|0 .. base|len in order.
module ro_mem_burst_responder #(
   parameter int RAM_ADDR_W   = 14,
   parameter int READ_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_request,
   input  logic [29:0]           i_addr,
   input  logic [4:0]            i_rlen,
   output logic                  o_ack,
   output logic                  o_rvalid,
   output logic [31:0]           o_rdata,
   output logic                  o_ram_en,
   output logic [RAM_ADDR_W-1:0] o_ram_addr,
   input  logic [31:0]           i_ram_rdata,
   input  logic                  i_ram_ready,
   output logic [1:0]            o_dbg_state
);

   // Handshake: the initiator holds i_request until it sees o_ack for one cycle; o_ack is only
   // raised in IDLE, so a request arriving mid-burst waits. Each accepted request yields exactly
   // len+1 o_rvalid pulses; there is no back-pressure on the returned stream.

   // Internal address width is at least 5 so the burst offset always fits next to the base.
   localparam int AW = (RAM_ADDR_W > 5) ? RAM_ADDR_W : 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [AW-1:0]           r_base;
   logic [AW-1:0]           w_base_nxt;
   logic [4:0]              r_len;
   logic [4:0]              w_len_nxt;
   logic [4:0]              r_offset;
   logic [4:0]              w_offset_nxt;
   logic [READ_LATENCY-1:0] r_vpipe;
   logic [READ_LATENCY-1:0] w_vpipe_shift;
   logic [AW-1:0]           w_addr_full;
   logic                    w_unused;

   // Bit 0 is the youngest read; bit READ_LATENCY-1 lines up with valid RAM data.
   assign w_vpipe_shift = r_vpipe << 1;

   // OR rather than add: the offset never carries out of the aligned block.
   assign w_addr_full = r_base | AW'(r_offset);

   assign o_ram_addr  = (r_state == S_ISSUE) ? w_addr_full[RAM_ADDR_W-1:0] : '0;
   assign o_rvalid    = r_vpipe[READ_LATENCY-1] & ~i_rst;
   assign o_rdata     = i_ram_rdata;
   assign o_dbg_state = r_state;

   // Upper request address bits alias onto the RAM and are intentionally dropped.
   assign w_unused = ^{i_addr, w_addr_full};

   always_comb begin
      w_state_nxt  = r_state;
      w_base_nxt   = r_base;
      w_len_nxt    = r_len;
      w_offset_nxt = r_offset;
      o_ack        = 1'b0;
      o_ram_en     = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ack = i_request;
            if (i_request) begin
               w_base_nxt   = i_addr[AW-1:0] & ~AW'(i_rlen);
               w_len_nxt    = i_rlen;
               w_offset_nxt = '0;
               w_state_nxt  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            o_ram_en = i_ram_ready;
            if (i_ram_ready) begin
               if (r_offset == r_len) begin
                  w_state_nxt = S_DRAIN;
               end else begin
                  w_offset_nxt = r_offset + 5'd1;
               end
            end
         end
         S_DRAIN: begin
            // No reads issue here, so the pipe is empty next cycle once only the last stage is set.
            if (w_vpipe_shift == '0) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (i_rst) begin
         o_ack    = 1'b0;
         o_ram_en = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_len    <= '0;
         r_offset <= '0;
         r_vpipe  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_base   <= w_base_nxt;
         r_len    <= w_len_nxt;
         r_offset <= w_offset_nxt;
         r_vpipe  <= w_vpipe_shift | READ_LATENCY'(o_ram_en);
      end
   end

endmodule

// File: tb/tb_ro_mem_burst_responder.sv
// Bench for ro_mem_burst_responder: two instances (L=1/14-bit RAM and L=3/4-bit RAM) with
// behavioural RAMs, a per-cycle recorder, and scenario tasks checked against a block-address model.
`timescale 1ns/1ps
module tb_ro_mem_burst_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [29:0] addr;
   logic [4:0]  rlen;
   logic        ready;

   logic        a_ack, a_rvalid, a_ram_en;
   logic [31:0] a_rdata, a_ram_rdata;
   logic [13:0] a_ram_addr;
   logic [1:0]  a_state;
   logic        b_ack, b_rvalid, b_ram_en;
   logic [31:0] b_rdata, b_ram_rdata, b_d1, b_d2;
   logic [3:0]  b_ram_addr;
   logic [1:0]  b_state;

   logic [31:0] mem_a [0:16383];
   logic [31:0] mem_b [0:15];

   bit          sel;
   logic        m_ack, m_rvalid, m_en;
   logic [31:0] m_rdata;
   logic [13:0] m_addr;
   logic [1:0]  m_state;

   int          n_cmp = 0;
   int          n_bad = 0;

   int          ack_c[$];
   int          rv_c[$];
   int          en_c[$];
   logic [31:0] rv_d[$];
   logic [13:0] en_a[$];
   logic [1:0]  st_q[$];
   int          rst_viol;
   int          rdy_pat[$];
   bit          rdy_rand;

   always #5 clk = ~clk;

   ro_mem_burst_responder #(.RAM_ADDR_W(14), .READ_LATENCY(1)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_request(req), .i_addr(addr), .i_rlen(rlen),
      .o_ack(a_ack), .o_rvalid(a_rvalid), .o_rdata(a_rdata), .o_ram_en(a_ram_en),
      .o_ram_addr(a_ram_addr), .i_ram_rdata(a_ram_rdata), .i_ram_ready(ready),
      .o_dbg_state(a_state)
   );

   ro_mem_burst_responder #(.RAM_ADDR_W(4), .READ_LATENCY(3)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_request(req), .i_addr(addr), .i_rlen(rlen),
      .o_ack(b_ack), .o_rvalid(b_rvalid), .o_rdata(b_rdata), .o_ram_en(b_ram_en),
      .o_ram_addr(b_ram_addr), .i_ram_rdata(b_ram_rdata), .i_ram_ready(ready),
      .o_dbg_state(b_state)
   );

   // Behavioural RAMs: data for the address presented on a cycle appears L cycles later.
   always @(posedge clk) a_ram_rdata <= mem_a[a_ram_addr];
   always @(posedge clk) begin
      b_d1        <= mem_b[b_ram_addr];
      b_d2        <= b_d1;
      b_ram_rdata <= b_d2;
   end

   always_comb begin
      if (sel) begin
         m_ack = b_ack; m_rvalid = b_rvalid; m_en = b_ram_en;
         m_rdata = b_rdata; m_addr = {10'd0, b_ram_addr}; m_state = b_state;
      end else begin
         m_ack = a_ack; m_rvalid = a_rvalid; m_en = a_ram_en;
         m_rdata = a_rdata; m_addr = a_ram_addr; m_state = a_state;
      end
   end

   // Reference model: word k of a burst lives at ((addr & ~rlen) | k), truncated to the RAM width.
   function automatic logic [13:0] model_addr(input bit s, input logic [29:0] a,
                                              input logic [4:0] l, input int k);
      logic [29:0] w;
      w = (a & ~{25'd0, l}) | 30'(k);
      return s ? {10'd0, w[3:0]} : w[13:0];
   endfunction

   function automatic logic [31:0] model_word(input bit s, input logic [29:0] a,
                                              input logic [4:0] l, input int k);
      logic [13:0] ra;
      ra = model_addr(s, a, l, k);
      return s ? mem_b[ra[3:0]] : mem_a[ra];
   endfunction

   function automatic int lat(input bit s);
      return s ? 3 : 1;
   endfunction

   // Drives one request (optionally a held second one) for ncyc cycles and records what the selected
   // instance does. Cycle 0 is the cycle the request first goes high.
   task automatic run_window(input int ncyc, input logic [29:0] a0, input logic [4:0] l0,
                             input bit hold, input logic [29:0] a1, input logic [4:0] l1,
                             input int rst_nrv);
      bit ack_prev;
      int n_ack;
      int rst_cnt;
      ack_prev = 1'b0; n_ack = 0; rst_cnt = 0; rst_viol = 0;
      ack_c.delete(); rv_c.delete(); en_c.delete(); rv_d.delete(); en_a.delete(); st_q.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req = 1'b1; addr = a0; rlen = l0;
         end else if (ack_prev) begin
            if (hold && n_ack == 1) begin
               addr = a1; rlen = l1;
            end else begin
               req = 1'b0;
            end
         end
         if (c >= 1 && c - 1 < rdy_pat.size()) ready = (rdy_pat[c-1] != 0);
         else if (rdy_rand) ready = ($urandom_range(0, 3) != 0);
         else ready = 1'b1;
         if (rst_cnt > 0) begin
            rst = 1'b1; rst_cnt--;
         end else begin
            rst = 1'b0;
         end
         @(negedge clk);
         st_q.push_back(m_state);
         if (rst && (m_ack || m_en || m_rvalid)) rst_viol++;
         if (m_ack) begin
            ack_c.push_back(c); n_ack++;
         end
         ack_prev = m_ack;
         if (m_en) begin
            en_c.push_back(c); en_a.push_back(m_addr);
         end
         if (m_rvalid) begin
            rv_c.push_back(c); rv_d.push_back(m_rdata);
            if (rv_c.size() == rst_nrv) rst_cnt = 2;
         end
      end
      req = 1'b0; rst = 1'b0; ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b1; addr = 30'h13; rlen = 5'd7; ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; #1;
         n_cmp++; if (m_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack sel=%0d got=%b exp=0", s, m_ack); end
         n_cmp++; if (m_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid sel=%0d got=%b exp=0", s, m_rvalid); end
         n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL reset_ram_en sel=%0d got=%b exp=0", s, m_en); end
         n_cmp++; if (m_addr !== 14'd0) begin n_bad++; $display("FAIL reset_ram_addr sel=%0d got=%h exp=0", s, m_addr); end
      end
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0; sel = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_aligned_fill();
      int n, l;
      sel = 1'b0; n = 8; l = lat(0);
      run_window(20, 30'h13, 5'd7, 1'b0, 30'h0, 5'd0, -1);
      n_cmp++; if (ack_c.size() != 1 || ack_c[0] != 0) begin n_bad++; $display("FAIL fill_ack n=%0d first=%0d exp one at 0", ack_c.size(), ack_c.size() ? ack_c[0] : -1); end
      n_cmp++; if (en_c.size() != n) begin n_bad++; $display("FAIL fill_en_count got=%0d exp=%0d", en_c.size(), n); end
      for (int k = 0; k < n && k < en_c.size(); k++) begin
         n_cmp++;
         if (en_c[k] != 1 + k || en_a[k] !== model_addr(0, 30'h13, 5'd7, k)) begin
            n_bad++; $display("FAIL fill_en k=%0d got cyc=%0d addr=%h exp cyc=%0d addr=%h", k, en_c[k], en_a[k], 1 + k, model_addr(0, 30'h13, 5'd7, k));
         end
      end
      n_cmp++; if (rv_c.size() != n) begin n_bad++; $display("FAIL fill_rv_count got=%0d exp=%0d", rv_c.size(), n); end
      for (int k = 0; k < n && k < rv_c.size(); k++) begin
         n_cmp++;
         if (rv_c[k] != 1 + l + k || rv_d[k] !== model_word(0, 30'h13, 5'd7, k)) begin
            n_bad++; $display("FAIL fill_rv k=%0d got cyc=%0d data=%h exp cyc=%0d data=%h", k, rv_c[k], rv_d[k], 1 + l + k, model_word(0, 30'h13, 5'd7, k));
         end
      end
      n_cmp++; if (st_q[n+l+1] !== 2'd0 || st_q[n+l] === 2'd0) begin n_bad++; $display("FAIL fill_idle_timing got st[%0d]=%0d st[%0d]=%0d exp busy then idle", n + l, st_q[n+l], n + l + 1, st_q[n+l+1]); end
   endtask

   task automatic test_single_word();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         run_window(12, 30'h25, 5'd0, 1'b0, 30'h0, 5'd0, -1);
         n_cmp++; if (rv_c.size() != 1) begin n_bad++; $display("FAIL single_count sel=%0d got=%0d exp=1", s, rv_c.size()); end
         if (rv_c.size() > 0) begin
            n_cmp++;
            if (rv_c[0] != 1 + lat(s[0]) || rv_d[0] !== model_word(s[0], 30'h25, 5'd0, 0)) begin
               n_bad++; $display("FAIL single_word sel=%0d got cyc=%0d data=%h exp cyc=%0d data=%h", s, rv_c[0], rv_d[0], 1 + lat(s[0]), model_word(s[0], 30'h25, 5'd0, 0));
            end
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_backpressure();
      int exp_en[$];
      sel = 1'b0;
      rdy_pat = '{1, 0, 0, 1, 1, 0, 1};
      for (int c = 1; exp_en.size() < 4; c++)
         if (c - 1 >= rdy_pat.size() || rdy_pat[c-1] != 0) exp_en.push_back(c);
      run_window(20, 30'h0, 5'd3, 1'b0, 30'h0, 5'd0, -1);
      rdy_pat.delete();
      n_cmp++; if (en_c.size() != 4) begin n_bad++; $display("FAIL bp_en_count got=%0d exp=4", en_c.size()); end
      n_cmp++; if (rv_c.size() != 4) begin n_bad++; $display("FAIL bp_rv_count got=%0d exp=4", rv_c.size()); end
      for (int k = 0; k < 4 && k < rv_c.size() && k < en_c.size(); k++) begin
         n_cmp++;
         if (en_c[k] != exp_en[k] || rv_c[k] != exp_en[k] + lat(0) || rv_d[k] !== model_word(0, 30'h0, 5'd3, k)) begin
            n_bad++; $display("FAIL bp_word k=%0d got en=%0d rv=%0d data=%h exp en=%0d rv=%0d data=%h", k, en_c[k], rv_c[k], rv_d[k], exp_en[k], exp_en[k] + lat(0), model_word(0, 30'h0, 5'd3, k));
         end
      end
   endtask

   task automatic test_back_to_back();
      int exp_ack2;
      logic [31:0] exp_q[$];
      int exp_c[$];
      sel = 1'b0;
      exp_ack2 = 4 + lat(0) + 1;
      for (int k = 0; k < 4; k++) begin exp_q.push_back(model_word(0, 30'h20, 5'd3, k)); exp_c.push_back(1 + lat(0) + k); end
      for (int k = 0; k < 4; k++) begin exp_q.push_back(model_word(0, 30'h40, 5'd3, k)); exp_c.push_back(exp_ack2 + 1 + lat(0) + k); end
      run_window(30, 30'h20, 5'd3, 1'b1, 30'h40, 5'd3, -1);
      n_cmp++; if (ack_c.size() != 2 || ack_c[1] != exp_ack2) begin n_bad++; $display("FAIL b2b_ack n=%0d second=%0d exp 2 with second at %0d", ack_c.size(), ack_c.size() > 1 ? ack_c[1] : -1, exp_ack2); end
      n_cmp++; if (rv_c.size() != 8) begin n_bad++; $display("FAIL b2b_rv_count got=%0d exp=8", rv_c.size()); end
      for (int k = 0; k < 8 && k < rv_c.size(); k++) begin
         n_cmp++;
         if (rv_c[k] != exp_c[k] || rv_d[k] !== exp_q[k]) begin
            n_bad++; $display("FAIL b2b_word k=%0d got cyc=%0d data=%h exp cyc=%0d data=%h", k, rv_c[k], rv_d[k], exp_c[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      sel = 1'b0;
      run_window(30, 30'h0, 5'd7, 1'b0, 30'h0, 5'd0, 3);
      n_cmp++; if (rv_c.size() != 3) begin n_bad++; $display("FAIL rstmid_rv_count got=%0d exp=3", rv_c.size()); end
      for (int k = 0; k < 3 && k < rv_c.size(); k++) begin
         n_cmp++; if (rv_d[k] !== model_word(0, 30'h0, 5'd7, k)) begin n_bad++; $display("FAIL rstmid_word k=%0d got=%h exp=%h", k, rv_d[k], model_word(0, 30'h0, 5'd7, k)); end
      end
      n_cmp++; if (rst_viol != 0) begin n_bad++; $display("FAIL rstmid_outputs_in_reset got=%0d active cycles exp=0", rst_viol); end
      run_window(12, 30'h8, 5'd1, 1'b0, 30'h0, 5'd0, -1);
      n_cmp++; if (rv_c.size() != 2) begin n_bad++; $display("FAIL rstmid_after_count got=%0d exp=2", rv_c.size()); end
      for (int k = 0; k < 2 && k < rv_c.size(); k++) begin
         n_cmp++;
         if (rv_c[k] != 1 + lat(0) + k || rv_d[k] !== model_word(0, 30'h8, 5'd1, k)) begin
            n_bad++; $display("FAIL rstmid_after_word k=%0d got cyc=%0d data=%h exp cyc=%0d data=%h", k, rv_c[k], rv_d[k], 1 + lat(0) + k, model_word(0, 30'h8, 5'd1, k));
         end
      end
   endtask

   task automatic test_aliasing();
      sel = 1'b1;
      run_window(25, 30'h3F8, 5'd7, 1'b0, 30'h0, 5'd0, -1);
      n_cmp++; if (en_c.size() != 8 || rv_c.size() != 8) begin n_bad++; $display("FAIL alias_count got en=%0d rv=%0d exp 8/8", en_c.size(), rv_c.size()); end
      for (int k = 0; k < 8 && k < en_c.size() && k < rv_c.size(); k++) begin
         n_cmp++;
         if (en_a[k] !== model_addr(1, 30'h3F8, 5'd7, k) || rv_d[k] !== model_word(1, 30'h3F8, 5'd7, k) || rv_c[k] != en_c[k] + lat(1)) begin
            n_bad++; $display("FAIL alias_word k=%0d got addr=%h data=%h lag=%0d exp addr=%h data=%h lag=%0d", k, en_a[k], rv_d[k], rv_c[k] - en_c[k], model_addr(1, 30'h3F8, 5'd7, k), model_word(1, 30'h3F8, 5'd7, k), lat(1));
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_random();
      logic [29:0] a;
      logic [4:0]  l;
      bit          s;
      logic [31:0] exp_q[$];
      for (int i = 0; i < 16384; i++) mem_a[i] = $urandom;
      for (int i = 0; i < 16; i++) mem_b[i] = $urandom;
      rdy_rand = 1'b1;
      for (int it = 0; it < 10; it++) begin
         s = $urandom_range(0, 1);
         a = 30'($urandom);
         l = 5'($urandom_range(0, 31));
         sel = s;
         exp_q.delete();
         for (int k = 0; k <= int'(l); k++) exp_q.push_back(model_word(s, a, l, k));
         run_window(160, a, l, 1'b0, 30'h0, 5'd0, -1);
         n_cmp++; if (ack_c.size() != 1 || rv_c.size() != int'(l) + 1 || en_c.size() != int'(l) + 1) begin
            n_bad++; $display("FAIL rand_counts it=%0d got ack=%0d en=%0d rv=%0d exp 1/%0d/%0d", it, ack_c.size(), en_c.size(), rv_c.size(), int'(l) + 1, int'(l) + 1);
         end
         for (int k = 0; k < rv_c.size() && k < en_c.size() && exp_q.size() > 0; k++) begin
            n_cmp++;
            if (rv_d[k] !== exp_q[0] || rv_c[k] != en_c[k] + lat(s) || en_a[k] !== model_addr(s, a, l, k)) begin
               n_bad++; $display("FAIL rand_word it=%0d k=%0d got data=%h lag=%0d addr=%h exp data=%h lag=%0d addr=%h", it, k, rv_d[k], rv_c[k] - en_c[k], en_a[k], exp_q[0], lat(s), model_addr(s, a, l, k));
            end
            void'(exp_q.pop_front());
         end
      end
      rdy_rand = 1'b0;
      sel = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem_a[i] = 32'h1000 + i;
      for (int i = 0; i < 16; i++) mem_b[i] = 32'h1000 + i;
      sel = 1'b0; rdy_rand = 1'b0;
      rst = 1'b1; req = 1'b0; addr = '0; rlen = '0; ready = 1'b1;
      test_reset();
      test_aligned_fill();
      test_single_word();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_burst();
      test_aliasing();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
